// File: rtl/mem_access_unit.sv
// mem_access_unit: multi-cycle data memory with byte/halfword/word loads and
// stores, a small IDLE/WAIT/DONE handshake FSM that holds the pipeline through
// the access, and a one-cycle AccessErr pulse on conflicting requests.
// Optional feature: define DMEM_MISALIGN_CHECK_EN to flag misaligned word and
// halfword accesses (no write, ReadData cleared, AccessErr raised).
module mem_access_unit #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  MemRead,
  input  logic [1:0]  MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        AccessErr
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

  state_t      state_r;
  logic [3:0]  cnt_r;
  logic [31:0] mem [DEPTH_WORDS];

  logic          req_s;
  logic          both_s;
  logic          misalign_s;
  logic          err_s;
  logic          go_done_s;
  logic          wr_en_s;
  logic          rd_upd_s;
  logic [AW-1:0] idx_s;
  logic [3:0]    be_s;
  logic [31:0]   wd_s;
  logic [31:0]   word_s;
  logic [31:0]   shifted_s;
  logic [31:0]   load_s;
  logic          unused_addr;

  assign req_s       = (MemRead != 2'b00) || (MemWrite != 2'b00);
  assign both_s      = (MemRead != 2'b00) && (MemWrite != 2'b00);
  assign idx_s       = Address[AW+1:2];
  assign word_s      = mem[idx_s];
  assign unused_addr = ^Address[31:AW+2];

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misalign_s = (((MemRead == 2'b01) || (MemWrite == 2'b01)) && (Address[1:0] != 2'b00)) ||
                      (((MemRead == 2'b11) || (MemWrite == 2'b11)) && Address[0]);
`else
  assign misalign_s = 1'b0;
`endif

  assign err_s = both_s || misalign_s;

  // The access completes on the edge that moves the FSM into DONE; reset blocks it.
  assign go_done_s = rst_n &&
                     (((state_r == IDLE) && req_s && (WAIT_CYCLES == 0)) ||
                      ((state_r == WAIT) && (cnt_r == 4'd0)));

  assign wr_en_s  = go_done_s && (MemWrite != 2'b00) && !err_s;
  assign rd_upd_s = go_done_s && !both_s && (misalign_s || (MemRead != 2'b00));

  // Stall covers the request cycle in IDLE plus every WAIT cycle; forced low in reset.
  assign Stall = rst_n && (((state_r == IDLE) && req_s) || (state_r == WAIT));

  // Store lane enables and lane-replicated store data.
  always_comb begin
    be_s = 4'b0000;
    wd_s = WriteData;
    case (MemWrite)
      2'b01: begin
        be_s = 4'b1111;
        wd_s = WriteData;
      end
      2'b10: begin
        be_s = 4'b0001 << Address[1:0];
        wd_s = {4{WriteData[7:0]}};
      end
      2'b11: begin
        be_s = Address[1] ? 4'b1100 : 4'b0011;
        wd_s = {2{WriteData[15:0]}};
      end
      default: begin
        be_s = 4'b0000;
        wd_s = WriteData;
      end
    endcase
  end

  // Load lane selection with sign extension for lb and lh.
  always_comb begin
    shifted_s = word_s >> {Address[1:0], 3'b000};
    load_s    = 32'h0000_0000;
    if (misalign_s) begin
      load_s = 32'h0000_0000;
    end else begin
      case (MemRead)
        2'b01:   load_s = word_s;
        2'b10:   load_s = {{24{shifted_s[7]}}, shifted_s[7:0]};
        2'b11:   load_s = Address[1] ? {{16{word_s[31]}}, word_s[31:16]}
                                     : {{16{word_s[15]}}, word_s[15:0]};
        default: load_s = 32'h0000_0000;
      endcase
    end
  end

  // Storage array: lane-masked write on DONE entry; contents are never reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          mem[idx_s][8*i +: 8] <= wd_s[8*i +: 8];
        end
      end
    end
  end

  // Access FSM with registered ReadData and AccessErr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= 4'd0;
      ReadData  <= 32'h0000_0000;
      AccessErr <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_s) begin
            cnt_r <= CNT_INIT;
            if (WAIT_CYCLES > 0) begin
              state_r <= WAIT;
            end else begin
              state_r <= DONE;
            end
          end
        end
        WAIT: begin
          if (cnt_r == 4'd0) begin
            state_r <= DONE;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= 4'd0;
        end
      endcase
      AccessErr <= go_done_s && err_s;
      if (rd_upd_s) begin
        ReadData <= load_s;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: one instance with WAIT_CYCLES=1 for the
// data-path tests and one with WAIT_CYCLES=3 for the reset-abort test.
// Expected results are queued when an access is issued and popped at DONE.
module tb_mem_access_unit;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          stalls;
    string       tag;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [1:0]  mr1, mw1, mr3, mw3;
  logic [31:0] ad1, wd1, ad3, wd3;
  logic [31:0] rd1, rd3;
  logic        st1, st3, er1, er3;
  int          sel;
  int          checks;
  int          errors;
  exp_t        sb_q[$];

  logic [31:0] rdata_m;
  logic        stall_m;
  logic        err_m;

  assign rdata_m = (sel == 1) ? rd3 : rd1;
  assign stall_m = (sel == 1) ? st3 : st1;
  assign err_m   = (sel == 1) ? er3 : er1;

  mem_access_unit #(.DEPTH_WORDS(256), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .MemRead(mr1), .MemWrite(mw1), .Address(ad1),
    .WriteData(wd1), .ReadData(rd1), .Stall(st1), .AccessErr(er1)
  );

  mem_access_unit #(.DEPTH_WORDS(256), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .MemRead(mr3), .MemWrite(mw3), .Address(ad3),
    .WriteData(wd3), .ReadData(rd3), .Stall(st3), .AccessErr(er3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic [1:0] r, input logic [1:0] w, input logic [31:0] a, input logic [31:0] d);
    if (sel == 1) begin
      mr3 = r; mw3 = w; ad3 = a; wd3 = d;
    end else begin
      mr1 = r; mw1 = w; ad1 = a; wd1 = d;
    end
  endtask

  task automatic access(input logic [1:0] r, input logic [1:0] w, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err,
                        input string tag);
    exp_t e;
    int   n;
    logic err_early;
    e.rd = exp_rd; e.err = exp_err; e.stalls = (sel == 1) ? 4 : 2; e.tag = tag;
    sb_q.push_back(e);
    @(negedge clk);
    drive(r, w, a, d);
    #1;
    n = 0;
    err_early = 1'b0;
    while (stall_m === 1'b1 && n < 40) begin
      err_early = err_early | err_m;
      n++;
      @(negedge clk);
      #1;
    end
    e = sb_q.pop_front();
    check({e.tag, " stall_cycles"}, 32'(n), 32'(e.stalls));
    check({e.tag, " err_while_stalled"}, {31'd0, err_early}, 32'd0);
    check({e.tag, " rdata_done"}, rdata_m, e.rd);
    check({e.tag, " err_done"}, {31'd0, err_m}, {31'd0, e.err});
    drive(2'b00, 2'b00, 32'd0, 32'd0);
    @(negedge clk);
    #1;
    check({e.tag, " err_idle"}, {31'd0, err_m}, 32'd0);
    check({e.tag, " rdata_hold"}, rdata_m, e.rd);
  endtask

  initial begin
    checks = 0; errors = 0; sel = 0;
    mr1 = 2'b00; mw1 = 2'b00; ad1 = 32'd0; wd1 = 32'd0;
    mr3 = 2'b00; mw3 = 2'b00; ad3 = 32'd0; wd3 = 32'd0;
    rst_n = 1'b0;

    // Reset state, with a request held on the inputs
    mr1 = 2'b01;
    repeat (2) @(negedge clk);
    #1;
    check("reset stall", {31'd0, st1}, 32'd0);
    check("reset rdata", rd1, 32'd0);
    check("reset err", {31'd0, er1}, 32'd0);
    mr1 = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;

    // Word round trip and sub-word loads
    access(2'b00, 2'b01, 32'h10, 32'h8877FF01, 32'h00000000, 1'b0, "sw_0x10");
    access(2'b01, 2'b00, 32'h10, 32'h0,        32'h8877FF01, 1'b0, "lw_0x10");
    access(2'b10, 2'b00, 32'h11, 32'h0,        32'hFFFFFFFF, 1'b0, "lb_0x11");
    access(2'b10, 2'b00, 32'h10, 32'h0,        32'h00000001, 1'b0, "lb_0x10");
    access(2'b11, 2'b00, 32'h12, 32'h0,        32'hFFFF8877, 1'b0, "lh_0x12");
    access(2'b11, 2'b00, 32'h10, 32'h0,        32'hFFFFFF01, 1'b0, "lh_0x10");

    // Byte store into lane 3 keeps other lanes
    access(2'b00, 2'b10, 32'h13, 32'h000000AB, 32'hFFFFFF01, 1'b0, "sb_0x13");
    access(2'b01, 2'b00, 32'h10, 32'h0,        32'hAB77FF01, 1'b0, "lw_after_sb");
    access(2'b10, 2'b00, 32'h13, 32'h0,        32'hFFFFFFAB, 1'b0, "lb_0x13");

    // Address wrap modulo 1 KiB
    access(2'b00, 2'b01, 32'h400, 32'h12345678, 32'hFFFFFFAB, 1'b0, "sw_0x400");
    access(2'b01, 2'b00, 32'h0,   32'h0,        32'h12345678, 1'b0, "lw_wrap");

    // Simultaneous read and write: error, no write, ReadData unchanged
    access(2'b01, 2'b01, 32'h10, 32'hDEADBEEF, 32'h12345678, 1'b1, "rw_conflict");
    access(2'b01, 2'b00, 32'h10, 32'h0,        32'hAB77FF01, 1'b0, "lw_after_conflict");

    // Misaligned halfword store
`ifdef DMEM_MISALIGN_CHECK_EN
    access(2'b00, 2'b11, 32'h11, 32'h0000BEEF, 32'h00000000, 1'b1, "sh_0x11_misaligned");
    access(2'b01, 2'b00, 32'h10, 32'h0,        32'hAB77FF01, 1'b0, "lw_after_sh");
`else
    access(2'b00, 2'b11, 32'h11, 32'h0000BEEF, 32'hAB77FF01, 1'b0, "sh_0x11_low_half");
    access(2'b01, 2'b00, 32'h10, 32'h0,        32'hAB77BEEF, 1'b0, "lw_after_sh");
`endif
    access(2'b00, 2'b11, 32'h12, 32'h00001234, 32'h00000000 | ((`ifdef DMEM_MISALIGN_CHECK_EN 32'hAB77FF01 `else 32'hAB77BEEF `endif)), 1'b0, "sh_0x12");
    access(2'b01, 2'b00, 32'h10, 32'h0, (`ifdef DMEM_MISALIGN_CHECK_EN 32'h1234FF01 `else 32'h1234BEEF `endif), 1'b0, "lw_after_sh_hi");

    // Longer wait with reset aborting accesses
    sel = 1;
    access(2'b00, 2'b01, 32'h20, 32'h11111111, 32'h00000000, 1'b0, "w3_sw_0x20");
    access(2'b01, 2'b00, 32'h20, 32'h0,        32'h11111111, 1'b0, "w3_lw_0x20");

    @(negedge clk);
    drive(2'b01, 2'b00, 32'h20, 32'h0);
    #1;
    check("abort_lw stall_req", {31'd0, st3}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_lw stall", {31'd0, st3}, 32'd0);
    check("abort_lw rdata", rd3, 32'd0);
    check("abort_lw err", {31'd0, er3}, 32'd0);
    @(negedge clk);
    drive(2'b00, 2'b00, 32'd0, 32'd0);
    rst_n = 1'b1;

    @(negedge clk);
    drive(2'b00, 2'b01, 32'h20, 32'h22222222);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_sw err", {31'd0, er3}, 32'd0);
    @(negedge clk);
    drive(2'b00, 2'b00, 32'd0, 32'd0);
    rst_n = 1'b1;

    access(2'b01, 2'b00, 32'h20, 32'h0,        32'h11111111, 1'b0, "w3_lw_no_abort_write");
    access(2'b00, 2'b01, 32'h24, 32'hCAFEF00D, 32'h11111111, 1'b0, "w3_sw_0x24");
    access(2'b01, 2'b00, 32'h24, 32'h0,        32'hCAFEF00D, 1'b0, "w3_lw_0x24");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, number of 32-bit storage words; power of two, at least 4.
REQ-002 Parameter WAIT_CYCLES, default 1, extra wait cycles per access; range 0..15.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port MemRead  input  2  load code: 00 none, 01 lw, 10 lb, 11 lh.
REQ-006 Port MemWrite  input  2  store code: 00 none, 01 sw, 10 sb, 11 sh.
REQ-007 Port Address  input  32  byte address of the access.
REQ-008 Port WriteData  input  32  store data; the byte or halfword is taken from the low bits.
REQ-009 Port ReadData  output  32  load result, sign-extended for lb and lh.
REQ-010 Port Stall  output  1  pipeline hold request; while it is high the pipeline shall keep all inputs stable.
REQ-011 Port AccessErr  output  1  one-cycle error pulse in the completion cycle.

Function
REQ-012 The FSM shall have three states: IDLE, WAIT, DONE.
REQ-013 A request exists when MemRead!=00 or MemWrite!=00.
REQ-014 In IDLE with a request present:
- Stall shall be 1 combinationally in that same cycle.
- The next state shall be WAIT if WAIT_CYCLES>0, otherwise DONE.
- The wait counter shall be loaded with WAIT_CYCLES-1.
REQ-015 In WAIT, Stall shall be 1; the counter decrements each cycle; the FSM moves to DONE on the edge where the counter is 0.
REQ-016 In DONE, Stall shall be 0 and ReadData is valid; the next state is IDLE unconditionally, so a held request is never re-issued.
REQ-017 Latency: a request first seen in cycle T completes in cycle T+1+WAIT_CYCLES; Stall is high for exactly 1+WAIT_CYCLES cycles.
REQ-018 Storage writes and the ReadData register update occur only on the edge entering DONE.
REQ-019 Word index shall be Address[log2(DEPTH_WORDS)+1:2]; higher address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS.
REQ-020 Byte lanes are little-endian:
- lb: lane Address[1:0], sign-extended from bit 7.
- lh: halfword Address[1], sign-extended from bit 15.
- lw: the full word.
REQ-021 Store lanes:
- sb writes only byte lane Address[1:0].
- sh writes only halfword lane Address[1].
- sw writes all four lanes.
- Unwritten lanes keep their prior contents.
REQ-022 ReadData shall hold its last load result through idle cycles and through completed stores.
REQ-023 If MemRead!=00 and MemWrite!=00 in the same request:
- No storage write occurs.
- ReadData is unchanged.
- AccessErr=1 in DONE.
- Latency is unchanged.
REQ-024 AccessErr shall be 0 in every cycle other than DONE.

Reset
REQ-025 On rst_n low, the unit shall asynchronously set: state=IDLE, wait counter=0, ReadData=0, AccessErr=0.
REQ-026 Stall shall read 0 while in reset.
REQ-027 Storage contents are not reset.
REQ-028 A reset asserted before the DONE-entry edge aborts the access: no storage write, no error.

Configuration
REQ-029 Macro DMEM_MISALIGN_CHECK_EN, when defined:
- A lw or sw with Address[1:0]!=00 is misaligned.
- A lh or sh with Address[0]=1 is misaligned.
- A misaligned access performs no write, sets ReadData=0, and sets AccessErr=1 in DONE.
- Latency is unchanged.
REQ-030 When DMEM_MISALIGN_CHECK_EN is undefined:
- Word accesses ignore Address[1:0].
- Half accesses ignore Address[0].
- Misalignment never raises AccessErr.

Verification
REQ-031 WAIT_CYCLES=1, sw Address=0x10 WriteData=0x8877FF01, then lw 0x10 -> Stall high 2 cycles per access; ReadData=0x8877FF01 in DONE.
REQ-032 After REQ-031 data is stored: lb 0x11 -> ReadData=0xFFFFFFFF; lb 0x10 -> 0x00000001; lh 0x12 -> 0xFFFF8877.
REQ-033 sb 0x13 WriteData=0x000000AB, then lw 0x10 -> ReadData=0xAB77FF01.
REQ-034 Wrap: with DEPTH_WORDS=256, sw 0x400 with 0x12345678, then lw 0x0 -> ReadData=0x12345678.
REQ-035 With DMEM_MISALIGN_CHECK_EN defined, sh 0x11 -> AccessErr pulses 1 cycle, storage unchanged; with MemRead=01 and MemWrite=01 together -> AccessErr=1 and no write.
REQ-036 WAIT_CYCLES=3, lw issued, rst_n pulsed low in the second WAIT cycle -> ReadData=0, Stall=0, state IDLE; a following sw then lw round-trips correctly.
